// File: rtl/tone_synth_pkg.sv
// Shared constants, FSM state type and key helpers for the tone_synth playback stage.
package tone_synth_pkg;

  localparam int unsigned HALF_W = 18;
  localparam int unsigned NOTE_W = 8;

  // Half-period in 100 MHz cycles for C4, D4, E4, F4, G4, A4, B4, C5.
  localparam logic [HALF_W-1:0] HALF_TBL [8] = '{
    18'd191110, 18'd170265, 18'd151685, 18'd143172,
    18'd127551, 18'd113636, 18'd101239, 18'd95557
  };

  typedef enum logic [1:0] {
    StSilent,
    StPlaying,
    StTail
  } state_e;

  // Lowest set bit wins; an all-zero word maps to 0 and is never used while silent.
  function automatic logic [2:0] lowest_key(input logic [NOTE_W-1:0] word);
    lowest_key = 3'd0;
    for (int i = NOTE_W - 1; i >= 0; i--) begin
      if (word[i]) lowest_key = 3'(i);
    end
  endfunction

endpackage

// File: rtl/tone_synth_note_filter.sv
// Glitch filter for the recorder note word: a new value is accepted only after it has been
// sampled unchanged on STABLE_CYCLES+1 consecutive edges.
module tone_synth_note_filter
  import tone_synth_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] nota,
  output logic [NOTE_W-1:0] accepted
);

  localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  logic [NOTE_W-1:0] cand_q, cand_d;
  logic [NOTE_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   stab_cnt_q, stab_cnt_d;

  always_comb begin
    cand_d     = nota;
    acc_d      = acc_q;
    stab_cnt_d = '0;
    // Count only while the candidate holds and still differs from what is accepted.
    if (nota == cand_q && cand_q != acc_q) begin
      if (stab_cnt_q == CntLast) begin
        acc_d = cand_q;
      end else begin
        stab_cnt_d = stab_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= '0;
      acc_q      <= '0;
      stab_cnt_q <= '0;
    end else begin
      cand_q     <= cand_d;
      acc_q      <= acc_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign accepted = acc_q;

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator for recorder playback: filters the key word, picks the lowest
// key and plays a phase-continuous tone that always ends low. TONE_SYNTH_OCTAVE_EN adds octave_up.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned DIV_SHIFT     = 0
) (
  input  logic              clk100mhz,
  input  logic              rst,
`ifdef TONE_SYNTH_OCTAVE_EN
  input  logic              octave_up,
`endif
  input  logic [NOTE_W-1:0] nota,
  output logic              audio_out,
  output logic              note_active,
  output logic [2:0]        cur_note
);

  logic [NOTE_W-1:0] accepted;
  logic [2:0]        key_idx;
  logic [HALF_W-1:0] half_sel;
  logic              at_end;

  state_e            state_q, state_d;
  logic              audio_q, audio_d;
  logic [HALF_W-1:0] tcnt_q, tcnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [2:0]        cur_note_q, cur_note_d;

  tone_synth_note_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_note_filter (
    .clk      (clk100mhz),
    .rst      (rst),
    .nota     (nota),
    .accepted (accepted)
  );

  assign key_idx = lowest_key(accepted);

  always_comb begin
    half_sel = HALF_TBL[key_idx] >> DIV_SHIFT;
`ifdef TONE_SYNTH_OCTAVE_EN
    if (octave_up) begin
      half_sel = HALF_TBL[key_idx] >> (DIV_SHIFT + 1);
    end
`endif
  end

  assign at_end = (tcnt_q == half_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    audio_d    = audio_q;
    tcnt_d     = tcnt_q;
    half_d     = half_q;
    cur_note_d = cur_note_q;
    unique case (state_q)
      StSilent: begin
        audio_d = 1'b0;
        tcnt_d  = '0;
        if (accepted != '0) begin
          state_d    = StPlaying;
          audio_d    = 1'b1;
          half_d     = half_sel;
          cur_note_d = key_idx;
        end
      end
      StPlaying, StTail: begin
        if (accepted == '0) begin
          // Finish the running half; either edge direction lands on a low, silent output.
          if (at_end) begin
            state_d = StSilent;
            audio_d = 1'b0;
            tcnt_d  = '0;
          end else begin
            state_d = StTail;
            tcnt_d  = tcnt_q + 1'b1;
          end
        end else begin
          state_d = StPlaying;
          if (at_end) begin
            audio_d    = ~audio_q;
            tcnt_d     = '0;
            half_d     = half_sel;
            cur_note_d = key_idx;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StSilent;
        audio_d = 1'b0;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state_q    <= StSilent;
      audio_q    <= 1'b0;
      tcnt_q     <= '0;
      half_q     <= '0;
      cur_note_q <= '0;
    end else begin
      state_q    <= state_d;
      audio_q    <= audio_d;
      tcnt_q     <= tcnt_d;
      half_q     <= half_d;
      cur_note_q <= cur_note_d;
    end
  end

  assign audio_out   = audio_q;
  assign note_active = (state_q != StSilent);
  assign cur_note    = cur_note_q;

endmodule
